// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipe start/drain controllers: depth width and
// FSM state encodings used by both controllers.
package pipe_ctrl_pkg;

  localparam int PDEPTH_W = 9;
  localparam logic [PDEPTH_W-1:0] VCNT_MAX = '1;

  typedef enum logic [2:0] {
    DRN_IDLE    = 3'b000,
    DRN_ARMED   = 3'b001,
    DRN_INHIBIT = 3'b010,
    DRN_DRAIN   = 3'b011,
    DRN_SETTLE  = 3'b100,
    DRN_DONE    = 3'b101
  } drain_state_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FILL = 2'b01,
    ST_RUN  = 2'b10
  } start_state_e;

  // Every state past Armed belongs to an in-flight drain.
  function automatic logic drain_busy(drain_state_e s);
    return !(s == DRN_IDLE || s == DRN_ARMED);
  endfunction

endpackage

// File: rtl/pipe_vld_cnt.sv
// Counts valid-tagged read responses during a drain (saturating) and
// compares the count against the latched depth.
module pipe_vld_cnt
  import pipe_ctrl_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  input  logic                clr_i,
  input  logic                re_i,
  input  logic                vld_i,
  input  logic [PDEPTH_W-1:0] pd_i,
  output logic [PDEPTH_W-1:0] vcnt_o,
  output logic                mismatch_o
);

  logic                re_dly_q;
  logic [PDEPTH_W-1:0] vcnt_q, vcnt_d;

  // NOTE: combinational blocks assign a default first so no path leaves a
  // variable unassigned, which would infer a latch.
  always_comb begin
    vcnt_d = vcnt_q;
    if (clr_i)
      vcnt_d = '0;
    else if (re_dly_q && vld_i && vcnt_q != VCNT_MAX)
      vcnt_d = vcnt_q + PDEPTH_W'(1);
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      re_dly_q <= 1'b0;
      vcnt_q   <= '0;
    end else begin
      re_dly_q <= re_i;
      vcnt_q   <= vcnt_d;
    end
  end

  assign vcnt_o     = vcnt_q;
  assign mismatch_o = (vcnt_q != pd_i);

endmodule

// File: rtl/pipe_drain_fsm.sv
// Drain controller for the delay pipe: inhibits writes, issues pd_q reads,
// optionally checks the valid count (macro DRAIN_DEPTH_CHECK_EN).
module pipe_drain_fsm
  import pipe_ctrl_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  input  logic [PDEPTH_W-1:0] PDEPTH,
  input  logic                RUN,
  input  logic                STOP,
  input  logic                VLD_OUT,
  output logic                RE,
  output logic                WE_INH,
  output logic                BUSY,
  output logic                DRAINED,
  output logic                DEPTH_ERR,
  output logic [PDEPTH_W-1:0] VCNT
);

  drain_state_e        state_q, state_d;
  logic                stop_q;
  logic [PDEPTH_W-1:0] pd_q, pd_d;
  logic [PDEPTH_W-1:0] rcnt_q, rcnt_d;
  logic                re_q, re_d;
  logic                we_inh_q, we_inh_d;
  logic                busy_q, busy_d;
  logic                drained_q, drained_d;
  logic                depth_err_q, depth_err_d;
  logic                stop_rise, accept, abort, cnt_mismatch;

  assign stop_rise = STOP & ~stop_q;
  assign accept    = (state_q == DRN_ARMED) && RUN && stop_rise;
  assign abort     = !RUN && (state_q == DRN_INHIBIT || state_q == DRN_DRAIN ||
                              state_q == DRN_SETTLE);

  // Async reset clears every output register, so RE/WE_INH drop mid-drain at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= DRN_IDLE;
      stop_q      <= 1'b0;
      pd_q        <= '0;
      rcnt_q      <= '0;
      re_q        <= 1'b0;
      we_inh_q    <= 1'b0;
      busy_q      <= 1'b0;
      drained_q   <= 1'b0;
      depth_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stop_q      <= STOP;
      pd_q        <= pd_d;
      rcnt_q      <= rcnt_d;
      re_q        <= re_d;
      we_inh_q    <= we_inh_d;
      busy_q      <= busy_d;
      drained_q   <= drained_d;
      depth_err_q <= depth_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pd_d    = pd_q;
    rcnt_d  = rcnt_q;
    unique case (state_q)
      DRN_IDLE:  if (RUN) state_d = DRN_ARMED;
      DRN_ARMED: begin
        if (!RUN) state_d = DRN_IDLE;
        else if (stop_rise) begin
          state_d = DRN_INHIBIT;
          pd_d    = PDEPTH;
          rcnt_d  = '0;
        end
      end
      DRN_INHIBIT: begin
        if (!RUN)           state_d = DRN_IDLE;
        else if (pd_q == '0) state_d = DRN_SETTLE;
        else                state_d = DRN_DRAIN;
      end
      DRN_DRAIN: begin
        rcnt_d = rcnt_q + PDEPTH_W'(1);
        // Leaving on rcnt == pd_q-1 keeps RE high for exactly pd_q cycles.
        if (!RUN)                                  state_d = DRN_IDLE;
        else if (rcnt_q == pd_q - PDEPTH_W'(1))    state_d = DRN_SETTLE;
      end
      DRN_SETTLE: state_d = RUN ? DRN_DONE : DRN_IDLE;
      DRN_DONE:   state_d = DRN_IDLE;
      default:    state_d = DRN_IDLE;
    endcase
  end

  // Outputs decode the next state so each one lines up with its state cycle.
  always_comb begin
    re_d        = (state_d == DRN_DRAIN);
    we_inh_d    = drain_busy(state_d);
    busy_d      = drain_busy(state_d);
    drained_d   = (state_d == DRN_DONE);
    depth_err_d = depth_err_q;
    if (accept)
      depth_err_d = 1'b0;
    else if (abort)
      depth_err_d = 1'b1;
    else if (state_q == DRN_DONE && cnt_mismatch)
      depth_err_d = 1'b1;
  end

`ifdef DRAIN_DEPTH_CHECK_EN
  logic [PDEPTH_W-1:0] vcnt;

  pipe_vld_cnt u_vld_cnt (
    .CLK        (CLK),
    .RST        (RST),
    .clr_i      (accept),
    .re_i       (re_q),
    .vld_i      (VLD_OUT),
    .pd_i       (pd_q),
    .vcnt_o     (vcnt),
    .mismatch_o (cnt_mismatch)
  );

  assign VCNT = vcnt;
`else
  logic unused_vld;

  assign unused_vld   = VLD_OUT;
  assign cnt_mismatch = 1'b0;
  assign VCNT         = '0;
`endif

  assign RE        = re_q;
  assign WE_INH    = we_inh_q;
  assign BUSY      = busy_q;
  assign DRAINED   = drained_q;
  assign DEPTH_ERR = depth_err_q;

endmodule
